sccb_cfg_sequencer: RTL
=======================

// Module: sccb_cfg_sequencer
// PURPOSE
//  Upstream feeder of the SCCB write master: walks the camera init table, presents reg_addr/reg_data
//  per entry, and issues one write per entry via a start/done handshake. Generates the 400 kHz bit
//  tick for the master, handles inline delay entries and end markers, and flags a stalled master.
// PARAMETERS
//  CLK_HZ        100_000_000  system clock frequency
//  TICK_HZ       400_000      tick rate; divisor DIV = CLK_HZ/TICK_HZ (250 at defaults)
//  ROM_DEPTH     76           init table entries, index 0..ROM_DEPTH-1
//  DELAY_CYC     1_000_000    clk cycles waited on a delay entry (10 ms)
//  TIMEOUT_TICKS 255          ticks allowed in WAIT_DONE before err
// PORTS
//  clk        in  1  system clock; all logic on posedge
//  reset_n    in  1  asynchronous active-low reset
//  cfg_start  in  1  1-cycle pulse; starts a configuration pass
//  tx_done    in  1  1-cycle pulse from master: current write's STOP completed
//  tick       out 1  1-cycle pulse every DIV clks while busy; else 0
//  tx_start   out 1  1-cycle pulse; reg_addr/reg_data valid and held until tx_done
//  reg_addr   out 8  register address of current entry
//  reg_data   out 8  register data of current entry
//  entry_idx  out 7  current table index
//  busy       out 1  high from accepted cfg_start until DONE/ERR
//  done       out 1  sticky: pass completed; cleared by next accepted cfg_start
//  err        out 1  sticky: timeout aborted pass; cleared by next accepted cfg_start
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE; all outputs 0; tick counter 0; entry_idx 0.
//  Table: internal case ROM, entry = {addr[7:0],data[7:0]}, sampled into registers in FETCH (1 clk).
//   {FF,FF} = end marker -> DONE, no write. {FF,F0} = delay marker -> DELAY, no write.
//  FSM:
//   IDLE      : cfg_start -> FETCH; idx<=0, done<=0, err<=0, busy<=1. cfg_start elsewhere ignored.
//   FETCH     : latch entry(idx) -> DECODE.
//   DECODE    : end marker -> DONE; delay marker -> DELAY (cnt<=0); else -> ISSUE.
//   ISSUE     : tx_start=1 for exactly one clk -> WAIT_DONE; tick-timeout counter cleared.
//   WAIT_DONE : tx_done -> NEXT; counter +1 per tick; reaching TIMEOUT_TICKS -> ERR.
//               tx_done and timeout in same clk: tx_done wins.
//   DELAY     : cnt+1 per clk; cnt==DELAY_CYC-1 -> NEXT.
//   NEXT      : idx==ROM_DEPTH-1 -> DONE; else idx<=idx+1 -> FETCH (no wrap).
//   DONE      : busy<=0, done<=1 -> IDLE.   ERR: busy<=0, err<=1 -> IDLE.
//  tx_start -> earliest next tx_start: needs tx_done + 3 clks (NEXT, FETCH, DECODE).
//  tx_done outside WAIT_DONE ignored. reg_addr/reg_data stable from ISSUE until FETCH.
//  Tick divider: free-runs only while busy; counts 0..DIV-1, tick=1 when count==DIV-1, then 0;
//   cleared to 0 when not busy, so first tick is DIV clks after entering busy.
//  Reset mid-pass: everything to reset values immediately; no partial resume.
// CONFIGURATION
//  SCCB_CFG_AUTOSTART_EN defined: one pass starts automatically 1 clk after reset release
//   (internal pulse equal to cfg_start); cfg_start still accepted later from IDLE.
//  Not defined: no pass runs until cfg_start.
// TESTING
//  1 reset_n=0 mid-WAIT_DONE -> all outputs 0, state IDLE, next cfg_start restarts at idx 0.
//  2 cfg_start, master model returns tx_done 40 ticks after each tx_start -> tx_start count equals
//    non-marker entries before {FF,FF}; reg_addr/reg_data match table; done=1, busy=0.
//  3 Entry 1 = {FF,F0} -> no tx_start for it; gap tx_done(idx0)->tx_start(idx2) = DELAY_CYC+6 clks.
//  4 Master never returns tx_done -> err=1 after 255 ticks (~255*250 clks), busy=0, done=0.
//  5 tick period: exactly 250 clks between pulses while busy; tick=0 in IDLE; cfg_start while
//    busy and spurious tx_done in FETCH -> no effect on idx or tx_start.
//  6 Build with SCCB_CFG_AUTOSTART_EN -> busy=1 one clk after reset release with no cfg_start.

Source files
------------

// File: rtl/sccb_cfg_sequencer.sv
// sccb_cfg_sequencer
//   Feeds the SCCB write master from the camera init table. Each table entry
//   is fetched, decoded and, unless it is a marker, handed to the master as
//   one write through a tx_start / tx_done handshake. It also generates the
//   bit tick the master runs on, executes inline delay entries, stops at the
//   end marker, and aborts the pass if the master stalls.
//
//   Optional build macro: SCCB_CFG_AUTOSTART_EN -- when defined, one pass
//   starts on its own on the first clock after reset release.
//
// Ports
//   clk        in   system clock, all logic on posedge
//   reset_n    in   asynchronous active-low reset
//   cfg_start  in   1-clk pulse, starts a pass (accepted only when idle)
//   tx_done    in   1-clk pulse from master, current write finished
//   tick       out  1-clk pulse every DIV clks while busy
//   tx_start   out  1-clk pulse, reg_addr/reg_data valid until tx_done
//   reg_addr   out  register address of current entry
//   reg_data   out  register data of current entry
//   entry_idx  out  current table index
//   busy       out  pass in progress
//   done       out  sticky, pass completed
//   err        out  sticky, pass aborted on master timeout
module sccb_cfg_sequencer #(
  parameter int CLK_HZ        = 100_000_000,
  parameter int TICK_HZ       = 400_000,
  parameter int ROM_DEPTH     = 76,
  parameter int DELAY_CYC     = 1_000_000,
  parameter int TIMEOUT_TICKS = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cfg_start,
  input  logic       tx_done,
  output logic       tick,
  output logic       tx_start,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_data,
  output logic [6:0] entry_idx,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = (DELAY_CYC > 1) ? $clog2(DELAY_CYC) : 1;
  localparam int TW  = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] DLY_LAST = CW'(DELAY_CYC - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_TICKS - 1);
  localparam logic [6:0]    LAST_IDX = 7'(ROM_DEPTH - 1);

  localparam logic [15:0] END_MARK = 16'hFFFF;
  localparam logic [15:0] DLY_MARK = 16'hFFF0;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_DONE,
    S_DELAY, S_NEXT, S_DONE, S_ERR
  } state_t;

  state_t        state, state_nx;
  logic          start_req;
  logic [DW-1:0] div_cnt;
  logic [CW-1:0] dly_cnt;
  logic [TW-1:0] to_cnt;
  logic [15:0]   rom_q;

`ifdef SCCB_CFG_AUTOSTART_EN
  // Low only during the first clock after reset release, which makes the
  // idle state see exactly one start request.
  logic auto_armed;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) auto_armed <= 1'b0;
    else          auto_armed <= 1'b1;
  end
  assign start_req = cfg_start | ~auto_armed;
`else
  assign start_req = cfg_start;
`endif

  // Bit tick divider. Held at 0 while idle so the first tick lands on the
  // DIV-th clock of busy; tick itself is gated so it is never seen idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        div_cnt <= '0;
    else if (!busy || div_cnt == DIV_LAST) div_cnt <= '0;
    else                                 div_cnt <= div_cnt + 1'b1;
  end
  assign tick = busy & (div_cnt == DIV_LAST);

  // Camera init table, {addr, data}. FFF0 = wait DELAY_CYC, FFFF = end.
  always_comb begin
    rom_q = END_MARK;
    case (entry_idx)
      7'd0:  rom_q = 16'h1280; 7'd1:  rom_q = 16'hFFF0; 7'd2:  rom_q = 16'h1204; 7'd3:  rom_q = 16'h1180;
      7'd4:  rom_q = 16'h0C00; 7'd5:  rom_q = 16'h3E00; 7'd6:  rom_q = 16'h0400; 7'd7:  rom_q = 16'h40D0;
      7'd8:  rom_q = 16'h3A04; 7'd9:  rom_q = 16'h1438; 7'd10: rom_q = 16'h4FB3; 7'd11: rom_q = 16'h50B3;
      7'd12: rom_q = 16'h5100; 7'd13: rom_q = 16'h523D; 7'd14: rom_q = 16'h53A7; 7'd15: rom_q = 16'h54E4;
      7'd16: rom_q = 16'h589E; 7'd17: rom_q = 16'h3DC0; 7'd18: rom_q = 16'h1714; 7'd19: rom_q = 16'h1802;
      7'd20: rom_q = 16'h3280; 7'd21: rom_q = 16'h1903; 7'd22: rom_q = 16'h1A7B; 7'd23: rom_q = 16'h030A;
      7'd24: rom_q = 16'h0F41; 7'd25: rom_q = 16'h1E00; 7'd26: rom_q = 16'h330B; 7'd27: rom_q = 16'h3C78;
      7'd28: rom_q = 16'h6900; 7'd29: rom_q = 16'h7400; 7'd30: rom_q = 16'hB084; 7'd31: rom_q = 16'hB10C;
      7'd32: rom_q = 16'hB20E; 7'd33: rom_q = 16'hB380; 7'd34: rom_q = 16'h703A; 7'd35: rom_q = 16'h7135;
      7'd36: rom_q = 16'h7211; 7'd37: rom_q = 16'h73F0; 7'd38: rom_q = 16'hA202; 7'd39: rom_q = 16'h7A20;
      7'd40: rom_q = 16'h7B10; 7'd41: rom_q = 16'h7C1E; 7'd42: rom_q = 16'h7D35; 7'd43: rom_q = 16'h7E5A;
      7'd44: rom_q = 16'h7F69; 7'd45: rom_q = 16'h8076; 7'd46: rom_q = 16'h8180; 7'd47: rom_q = 16'h8288;
      7'd48: rom_q = 16'h838F; 7'd49: rom_q = 16'h8496; 7'd50: rom_q = 16'h85A3; 7'd51: rom_q = 16'h86AF;
      7'd52: rom_q = 16'h87C4; 7'd53: rom_q = 16'h88D7; 7'd54: rom_q = 16'h89E8; 7'd55: rom_q = 16'h13E0;
      7'd56: rom_q = 16'h0000; 7'd57: rom_q = 16'h1000; 7'd58: rom_q = 16'h0D40; 7'd59: rom_q = 16'h1418;
      7'd60: rom_q = 16'hA505; 7'd61: rom_q = 16'hAB07; 7'd62: rom_q = 16'h2495; 7'd63: rom_q = 16'h2533;
      7'd64: rom_q = 16'h26E3; 7'd65: rom_q = 16'h9F78; 7'd66: rom_q = 16'hA068; 7'd67: rom_q = 16'hA103;
      7'd68: rom_q = 16'hA6D8; 7'd69: rom_q = 16'hA7D8; 7'd70: rom_q = 16'hA8F0; 7'd71: rom_q = 16'hA990;
      7'd72: rom_q = 16'hAA94; 7'd73: rom_q = 16'h13E5; 7'd74: rom_q = 16'h1100; 7'd75: rom_q = 16'hFFFF;
      default: rom_q = END_MARK;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tx_start = 1'b0;
    case (state)
      S_IDLE:   if (start_req) state_nx = S_FETCH;
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: begin
        if ({reg_addr, reg_data} == END_MARK)      state_nx = S_DONE;
        else if ({reg_addr, reg_data} == DLY_MARK) state_nx = S_DELAY;
        else                                       state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        tx_start = 1'b1;
        state_nx = S_WAIT_DONE;
      end
      // A completion arriving on the same clock as the last allowed tick
      // still counts as success.
      S_WAIT_DONE: begin
        if (tx_done)                          state_nx = S_NEXT;
        else if (tick && (to_cnt == TO_LAST)) state_nx = S_ERR;
      end
      S_DELAY:  if (dly_cnt == DLY_LAST) state_nx = S_NEXT;
      S_NEXT:   state_nx = (entry_idx == LAST_IDX) ? S_DONE : S_FETCH;
      S_DONE:   state_nx = S_IDLE;
      S_ERR:    state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry_idx <= '0;
      reg_addr  <= '0;
      reg_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      dly_cnt   <= '0;
      to_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: if (start_req) begin
          entry_idx <= '0;
          busy      <= 1'b1;
          done      <= 1'b0;
          err       <= 1'b0;
        end
        S_FETCH:     {reg_addr, reg_data} <= rom_q;
        S_DECODE:    dly_cnt <= '0;
        S_ISSUE:     to_cnt  <= '0;
        S_WAIT_DONE: if (tick) to_cnt <= to_cnt + 1'b1;
        S_DELAY:     dly_cnt <= dly_cnt + 1'b1;
        S_NEXT:      if (entry_idx != LAST_IDX) entry_idx <= entry_idx + 1'b1;
        S_DONE: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        S_ERR: begin
          busy <= 1'b0;
          err  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
